cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Host-side sequencer for the pipelined cpu. Owns the cpu's external IMEM/DMEM ports, reset and enable.
//  One session: hold cpu in reset, stream program words into IMEM, release reset, then assert enable
//  for a counted number of cycles. Afterwards it stops the cpu and streams DMEM words back to the host.
// PARAMETERS
//  IMEM_DEPTH  512   IMEM words; prog_len is clamped to this value
//  DMEM_DEPTH  1024  DMEM words; dump_len is clamped to this value
//  LEN_W       11    width of prog_len / dump_len / word counters
//  CNT_W       32    width of run_cycles / cycle counter
// PORTS
//  clk             in   1      single clock
//  arst            in   1      asynchronous, active-high reset
//  start           in   1      1-cycle pulse; starts a session; ignored unless IDLE
//  prog_len        in   LEN_W  words to load; sampled at start
//  run_cycles      in   CNT_W  enable cycles; sampled at start
//  dump_len        in   LEN_W  DMEM words to return; sampled at start
//  ld_valid/ld_ready in/out 1  program stream handshake; transfer when both are high
//  ld_data         in   32     instruction word
//  dp_valid/dp_ready out/in 1  dump stream handshake
//  dp_data         out  32     DMEM word
//  busy, done      out  1      busy: state!=IDLE; done: 1-cycle pulse at end of session
//  cpu_arst_n      out  1      drives cpu arst_n
//  cpu_enable      out  1      drives cpu enable
//  imem_addr/wen/ren/wdata  out 32/1/1/32  to cpu addr_ext/wen_ext/ren_ext/wdata_ext
//  dmem_addr/wen/ren/wdata  out 32/1/1/32  to cpu addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2
//  dmem_rdata      in   32     from cpu rdata_ext_2; valid 1 cycle after dmem_ren
// BEHAVIOUR
//  Reset values: state=IDLE, cpu_arst_n=0, cpu_enable=0, all wen/ren=0, all addr/wdata=0,
//    ld_ready=0, dp_valid=0, dp_data=0, busy=0, done=0.
//  External addresses are byte addresses: word i maps to 4*i. dmem_wen is always 0.
//  FSM states: IDLE, LOAD, REL, RUN, RD, WAIT, OUT, FIN.
//  IDLE: cpu_arst_n=0. On start: latch clamped lengths and run_cycles, clear word counter.
//    Next state is LOAD if prog_len>0, otherwise REL.
//  LOAD: ld_ready=1 and cpu_arst_n=0. On each transfer, imem_wen=1 in the same cycle,
//    imem_addr=4*k, imem_wdata=ld_data, then k++. After word prog_len-1, go to REL.
//    Write is combinational from handshake, 1 word/cycle.
//  REL: cpu_arst_n=1 and cpu_enable=0 for exactly 1 cycle. Next state is RUN if run_cycles>0,
//    otherwise RD/FIN per dump_len.
//  RUN: cpu_enable=1 for exactly run_cycles consecutive cycles, counted by a down-counter.
//    Then go to RD if dump_len>0, otherwise FIN. cpu_enable drops the cycle the state is left.
//  RD: dmem_ren=1, dmem_addr=4*j. WAIT: one cycle for SRAM latency; capture dmem_rdata into dp_data.
//  OUT: dp_valid=1 and dp_data is held stable until dp_ready. On handshake, j++.
//    Go to FIN after word dump_len-1, otherwise back to RD. Throughput is 1 word per 3 cycles minimum.
//  FIN: done=1 for one cycle, then IDLE. cpu_arst_n returns to 0 in IDLE.
//  Boundaries: prog_len=0 skips LOAD. run_cycles=0 skips RUN. dump_len=0 skips RD/WAIT/OUT.
//    start while busy has no effect. Lengths above depth are clamped.
//    Counters compare against len-1, with no wrap.
//    arst mid-session: immediate IDLE, cpu held in reset, partial IMEM contents are left as-is.
//  ld_ready is 0 outside LOAD. dp_valid is never withdrawn before its handshake.
// STRUCTURE
//  Package cpu_run_ctrl_pkg: state encoding localparams and function word2byte(idx) = {idx,2'b00}.
//  Sub-module stream_hold_reg: a valid/ready output register holding dp_data/dp_valid,
//    with load and clear controls. Counters and FSM live in the top.
// TESTING
//  1. prog_len=3, ld_valid continuous -> imem_wen on 3 consecutive cycles at addresses 0,4,8;
//     cpu_arst_n=0 throughout.
//  2. ld_valid toggling 1,0,1,0 -> only transfers write, and addresses stay contiguous.
//  3. run_cycles=5 -> cpu_enable high for exactly 5 cycles, 1 cycle after REL; then 0.
//  4. Preload DMEM[0..3]=0xA,0xB,0xC,0xD, dump_len=4, dp_ready low 2 cycles per word
//     -> dp_data sequence A,B,C,D stable while dp_valid; done pulse once.
//  5. prog_len=0, run_cycles=0, dump_len=0 -> IDLE->REL->FIN; done 2 cycles after start.
//  6. arst asserted during RUN, and start pulsed while busy -> outputs return to reset values
//     asynchronously; the second start is ignored.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared sizes, FSM state encoding and word-to-byte address helper
package cpu_run_ctrl_pkg;
  localparam int IMEM_DEPTH = 512;
  localparam int DMEM_DEPTH = 1024;
  localparam int LEN_W = 11;
  localparam int CNT_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REL, S_RUN, S_RD, S_WAIT, S_OUT, S_FIN} state_e;
  function automatic logic [31:0] word2byte(input logic [LEN_W-1:0] idx);
    return 32'({idx, 2'b00});
  endfunction
endpackage

// File: rtl/stream_hold_reg.sv
// stream_hold_reg: valid/ready output register, data held until the consumer takes it
module stream_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= load_i | (valid_q & ~clr_i);
      if (load_i) data_q <= data_i;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host sequencer that loads IMEM, runs the cpu for a counted time and dumps DMEM
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] prog_len_i,
  input  logic [CNT_W-1:0] run_cycles_i,
  input  logic [LEN_W-1:0] dump_len_i,
  input  logic             ld_valid_i,
  output logic             ld_ready_o,
  input  logic [31:0]      ld_data_i,
  output logic             dp_valid_o,
  input  logic             dp_ready_i,
  output logic [31:0]      dp_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cpu_arst_n_o,
  output logic             cpu_enable_o,
  output logic [31:0]      imem_addr_o,
  output logic             imem_wen_o,
  output logic             imem_ren_o,
  output logic [31:0]      imem_wdata_o,
  output logic [31:0]      dmem_addr_o,
  output logic             dmem_wen_o,
  output logic             dmem_ren_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic [31:0]      dmem_rdata_i
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] prog_q, prog_d, dump_q, dump_d, cnt_q, cnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             ld_xfer, dp_xfer, last_ld, last_dp;
  assign ld_xfer = state_q == S_LOAD && ld_valid_i;
  assign dp_xfer = state_q == S_OUT && dp_valid_o && dp_ready_i;
  assign last_ld = cnt_q == prog_q - LEN_W'(1);
  assign last_dp = cnt_q == dump_q - LEN_W'(1);
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    dump_d  = dump_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        prog_d  = prog_len_i > LEN_W'(IMEM_DEPTH) ? LEN_W'(IMEM_DEPTH) : prog_len_i;
        dump_d  = dump_len_i > LEN_W'(DMEM_DEPTH) ? LEN_W'(DMEM_DEPTH) : dump_len_i;
        run_d   = run_cycles_i;
        cnt_d   = '0;
        state_d = prog_len_i != '0 ? S_LOAD : S_REL;
      end
      // the word counter is reused for the dump, so it restarts when loading ends
      S_LOAD: if (ld_xfer) begin
        cnt_d   = last_ld ? '0 : cnt_q + LEN_W'(1);
        state_d = last_ld ? S_REL : S_LOAD;
      end
      S_REL: state_d = run_q != '0 ? S_RUN : dump_q != '0 ? S_RD : S_FIN;
      S_RUN: begin
        run_d = run_q - CNT_W'(1);
        if (run_q == CNT_W'(1)) state_d = dump_q != '0 ? S_RD : S_FIN;
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: state_d = S_OUT;
      S_OUT: if (dp_xfer) begin
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = last_dp ? S_FIN : S_RD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state_q <= S_IDLE;
      prog_q  <= '0;
      dump_q  <= '0;
      run_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      dump_q  <= dump_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  stream_hold_reg #(.W(32)) u_hold (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .load_i (state_q == S_WAIT),
    .clr_i  (dp_xfer),
    .data_i (dmem_rdata_i),
    .valid_o(dp_valid_o),
    .data_o (dp_data_o)
  );
  assign busy_o       = state_q != S_IDLE;
  assign done_o       = state_q == S_FIN;
  assign cpu_arst_n_o = !(state_q == S_IDLE || state_q == S_LOAD);
  assign cpu_enable_o = state_q == S_RUN;
  assign ld_ready_o   = state_q == S_LOAD;
  assign imem_wen_o   = ld_xfer;
  assign imem_ren_o   = 1'b0;
  assign imem_addr_o  = ld_xfer ? word2byte(cnt_q) : '0;
  assign imem_wdata_o = ld_xfer ? ld_data_i : '0;
  assign dmem_ren_o   = state_q == S_RD;
  assign dmem_wen_o   = 1'b0;
  assign dmem_addr_o  = dmem_ren_o ? word2byte(cnt_q) : '0;
  assign dmem_wdata_o = '0;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: session table plus scoreboards for IMEM writes and dumped DMEM words
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;
  typedef struct {
    int pl, rc, dl, ld, enf, en, dp, lat;
    bit tog;
    int gap;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  logic             clk = 1'b0, arst = 1'b1, start = 1'b0;
  logic [LEN_W-1:0] prog_len = '0, dump_len = '0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic             ld_valid = 1'b0, ld_ready, dp_valid, dp_ready = 1'b0;
  logic [31:0]      ld_data = '0, dp_data;
  logic             busy, done, cpu_arst_n, cpu_enable;
  logic [31:0]      imem_addr, imem_wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic             imem_wen, imem_ren, dmem_wen, dmem_ren;
  logic [31:0]      dmem [DMEM_DEPTH];
  wr_t              iq[$];
  logic [31:0]      dq[$];
  int               pass = 0, total = 0;
  int               ld_cnt = 0, dn = 0, vwait = 0;
  bit               hold = 0;
  logic [31:0]      prev_dp = '0;
  vec_t             tbl[6];
  cpu_run_ctrl dut (
    .clk_i(clk), .arst_i(arst), .start_i(start), .prog_len_i(prog_len),
    .run_cycles_i(run_cycles), .dump_len_i(dump_len), .ld_valid_i(ld_valid),
    .ld_ready_o(ld_ready), .ld_data_i(ld_data), .dp_valid_o(dp_valid),
    .dp_ready_i(dp_ready), .dp_data_o(dp_data), .busy_o(busy), .done_o(done),
    .cpu_arst_n_o(cpu_arst_n), .cpu_enable_o(cpu_enable), .imem_addr_o(imem_addr),
    .imem_wen_o(imem_wen), .imem_ren_o(imem_ren), .imem_wdata_o(imem_wdata),
    .dmem_addr_o(dmem_addr), .dmem_wen_o(dmem_wen), .dmem_ren_o(dmem_ren),
    .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (dmem_ren) dmem_rdata <= dmem[dmem_addr[11:2]];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask
  task automatic monitor();
    wr_t w;
    logic [31:0] d;
    if (imem_wen) begin
      chk("imem_wen_in_reset", cpu_arst_n, 1'b0);
      if (iq.size() == 0) begin
        total++;
        $display("FAIL imem_extra: write at 0x%0h, want no write", imem_addr);
      end else begin
        w = iq.pop_front();
        chk("imem_addr", imem_addr, w.a);
        chk("imem_wdata", imem_wdata, w.d);
      end
    end
    if (ld_valid && ld_ready) ld_cnt++;
    if (dmem_ren) chk("dmem_wen", dmem_wen, 1'b0);
    if (done) dn++;
    if (dp_valid) begin
      if (hold) chk("dp_data_stable", dp_data, prev_dp);
      if (dp_ready) begin
        if (dq.size() == 0) begin
          total++;
          $display("FAIL dump_extra: word 0x%0h, want no word", dp_data);
        end else begin
          d = dq.pop_front();
          chk("dp_data", dp_data, d);
        end
        vwait = 0;
        hold = 0;
      end else begin
        vwait++;
        hold = 1;
        prev_dp = dp_data;
      end
    end
  endtask
  task automatic run_row(input vec_t v, input int id);
    int lat;
    bit seen;
    for (int i = 0; i < v.ld; i++) iq.push_back('{32'(4 * i), 32'hC0DE_0000 + 32'(ld_cnt + i)});
    for (int i = 0; i < v.dp; i++) dq.push_back(dmem[i]);
    dn = 0; vwait = 0; hold = 0; seen = 0; lat = 0;
    @(posedge clk); #1;
    start = 1'b1; prog_len = LEN_W'(v.pl); run_cycles = CNT_W'(v.rc); dump_len = LEN_W'(v.dl);
    ld_valid = 1'b0; dp_ready = 1'b0; ld_data = 32'hC0DE_0000 + 32'(ld_cnt);
    @(negedge clk); monitor();
    for (int n = 1; n <= v.lat + 10 && !seen; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ld_valid = v.tog ? (n % 2 == 1) : 1'b1;
      ld_data = 32'hC0DE_0000 + 32'(ld_cnt);
      dp_ready = vwait >= v.gap;
      @(negedge clk); monitor();
      chk($sformatf("row%0d cpu_enable@%0d", id, n), cpu_enable, 32'(n >= v.enf && n < v.enf + v.en));
      if (done) begin seen = 1; lat = n; end
    end
    if (!seen) begin
      total++;
      $display("FAIL row%0d timeout: no done, want done at cycle %0d", id, v.lat);
    end else chk($sformatf("row%0d done_latency", id), lat, v.lat);
    ld_valid = 1'b0; dp_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); monitor();
    chk($sformatf("row%0d done_pulse", id), done, 1'b0);
    chk($sformatf("row%0d busy_end", id), busy, 1'b0);
    chk($sformatf("row%0d cpu_arst_n_end", id), cpu_arst_n, 1'b0);
    chk($sformatf("row%0d done_count", id), dn, 1);
    chk($sformatf("row%0d imem_left", id), iq.size(), 0);
    chk($sformatf("row%0d dump_left", id), dq.size(), 0);
    iq.delete(); dq.delete();
  endtask
  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = i < 4 ? 32'hA + 32'(i) : 32'hD000_0000 + 32'(i);
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 2, 1'b0, 0};
    tbl[1] = '{3, 5, 0, 3, 5, 5, 0, 10, 1'b0, 0};
    tbl[2] = '{4, 0, 0, 4, 0, 0, 0, 9, 1'b1, 0};
    tbl[3] = '{0, 0, 4, 0, 0, 0, 4, 22, 1'b0, 2};
    tbl[4] = '{2, 1, 1, 2, 4, 1, 1, 8, 1'b0, 0};
    tbl[5] = '{600, 0, 1100, 512, 0, 0, 1024, 3586, 1'b0, 0};
    #2;
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst cpu_arst_n", cpu_arst_n, 1'b0);
    chk("rst cpu_enable", cpu_enable, 1'b0);
    chk("rst ld_ready", ld_ready, 1'b0);
    chk("rst dp_valid", dp_valid, 1'b0);
    chk("rst dp_data", dp_data, 32'h0);
    chk("rst imem_wen", imem_wen, 1'b0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst dmem_ren", dmem_ren, 1'b0);
    chk("rst dmem_addr", dmem_addr, 32'h0);
    @(negedge clk); arst = 1'b0;
    for (int r = 0; r < 6; r++) run_row(tbl[r], r);
    // start while busy is dropped, then reset lands mid-RUN
    @(posedge clk); #1;
    start = 1'b1; prog_len = '0; run_cycles = 20; dump_len = '0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1; prog_len = 5; run_cycles = 0;
    @(negedge clk);
    chk("busy_start busy", busy, 1'b1);
    chk("busy_start cpu_enable", cpu_enable, 1'b1);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("busy_start still_run", cpu_enable, 1'b1);
    chk("busy_start ld_ready", ld_ready, 1'b0);
    #2 arst = 1'b1;
    #1;
    chk("arst cpu_enable", cpu_enable, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst cpu_arst_n", cpu_arst_n, 1'b0);
    chk("arst done", done, 1'b0);
    chk("arst ld_ready", ld_ready, 1'b0);
    #1 arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_arst busy", busy, 1'b0);
      chk("post_arst cpu_enable", cpu_enable, 1'b0);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
